// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, ROM address, IF/ID register, redirect/flush.
// Optional feature: define FETCH_RANGE_CHECK_EN to halt on out-of-range fetch.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_DEPTH = 32,
  parameter logic [31:0] NOP_INST  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] fetch_cnt,
  output logic        fetch_err
);

  if (ROM_DEPTH == 0 || ROM_DEPTH > 32'h3FFF_FFFF) begin : g_bad_depth
    $error("ROM_DEPTH must be in 1 .. 2^30-1");
  end

  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        stall;
  logic [31:0] pc_plus4;

  assign stall    = id_valid_q & ~id_ready;
  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_RANGE_CHECK_EN
  localparam logic [32:0] ROM_BYTES = 33'(ROM_DEPTH) * 33'd4;
  logic fetch_err_q, fetch_err_d;
  logic out_of_range;
  assign out_of_range = {1'b0, pc_q} >= ROM_BYTES;
`endif

  // Next-state: flush beats stall, stall beats issue.
  always_comb begin
    pc_d        = pc_q;
    id_valid_d  = id_valid_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    fetch_cnt_d = fetch_cnt_q;
`ifdef FETCH_RANGE_CHECK_EN
    fetch_err_d = fetch_err_q;
`endif
    if (br_taken) begin
      pc_d       = br_target & ~32'h3;
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else if (stall) begin
      pc_d = pc_q;
`ifdef FETCH_RANGE_CHECK_EN
    end else if (out_of_range) begin
      id_valid_d  = 1'b0;
      fetch_err_d = 1'b1;
`endif
    end else begin
      id_inst_d   = rom_inst;
      id_pc_d     = pc_q;
      id_pc4_d    = pc_plus4;
      id_valid_d  = 1'b1;
      pc_d        = pc_plus4;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC & ~32'h3;
      id_valid_q  <= 1'b0;
      id_inst_q   <= NOP_INST;
      id_pc_q     <= 32'h0;
      id_pc4_q    <= 32'h0;
      fetch_cnt_q <= 32'h0;
    end else begin
      pc_q        <= pc_d;
      id_valid_q  <= id_valid_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

`ifdef FETCH_RANGE_CHECK_EN
  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) fetch_err_q <= 1'b0;
    else     fetch_err_q <= fetch_err_d;
  end
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign rom_addr  = pc_q;
  assign id_valid  = id_valid_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 32-word combinational ROM.
// Covers reset, issue, stall, flush, range check / alias and PC wrap.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] fetch_cnt;
  logic        fetch_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .RESET_PC (32'h0),
    .ROM_DEPTH(32),
    .NOP_INST (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rom_addr (rom_addr),
    .rom_inst (rom_inst),
    .br_taken (br_taken),
    .br_target(br_target),
    .id_ready (id_ready),
    .id_valid (id_valid),
    .id_inst  (id_inst),
    .id_pc    (id_pc),
    .id_pc4   (id_pc4),
    .fetch_cnt(fetch_cnt),
    .fetch_err(fetch_err)
  );

  logic [4:0] widx;
  assign widx = rom_addr[6:2];

  always_comb begin
    case (widx)
      5'd0:    rom_inst = 32'h3c01_1010;
      5'd1:    rom_inst = 32'h3c02_0101;
      5'd2:    rom_inst = 32'h0022_1820;
      5'd3:    rom_inst = 32'h0022_1822;
      default: rom_inst = 32'hA5A5_0000 | {27'h0, widx};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".valid"}, {31'h0, id_valid}, 32'h0);
    chk({tag, ".inst"}, id_inst, 32'h0);
    chk({tag, ".pc"}, id_pc, 32'h0);
    chk({tag, ".pc4"}, id_pc4, 32'h0);
    chk({tag, ".cnt"}, fetch_cnt, 32'h0);
    chk({tag, ".err"}, {31'h0, fetch_err}, 32'h0);
    chk({tag, ".addr"}, rom_addr, 32'h0);
  endtask

  task automatic chk_id(input string tag, input logic [31:0] inst,
                        input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, ".valid"}, {31'h0, id_valid}, 32'h1);
    chk({tag, ".inst"}, id_inst, inst);
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".pc4"}, id_pc4, pc + 32'd4);
    chk({tag, ".cnt"}, fetch_cnt, cnt);
  endtask

  initial begin
    rst       = 1'b1;
    br_taken  = 1'b0;
    br_target = 32'h0;
    id_ready  = 1'b0;
    step();
    chk_rst("rst0");

    rst      = 1'b0;
    id_ready = 1'b1;
    step();
    chk_id("iss0", 32'h3c01_1010, 32'h0, 32'd1);
    step();
    chk_id("iss1", 32'h3c02_0101, 32'h4, 32'd2);
    step();
    chk_id("iss2", 32'h0022_1820, 32'h8, 32'd3);
    chk("iss2.addr", rom_addr, 32'hC);

    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_id("stall", 32'h0022_1820, 32'h8, 32'd3);
      chk("stall.addr", rom_addr, 32'hC);
    end
    id_ready = 1'b1;
    step();
    chk_id("rel", 32'h0022_1822, 32'hC, 32'd4);
    chk("rel.addr", rom_addr, 32'h10);

    br_taken  = 1'b1;
    br_target = 32'h0000_000A;
    id_ready  = 1'b0;
    step();
    chk("br.valid", {31'h0, id_valid}, 32'h0);
    chk("br.inst", id_inst, 32'h0);
    chk("br.addr", rom_addr, 32'h8);
    chk("br.cnt", fetch_cnt, 32'd4);
    br_taken = 1'b0;
    id_ready = 1'b1;
    step();
    chk_id("br.tgt", 32'h0022_1820, 32'h8, 32'd5);

    id_ready = 1'b0;
    step();
    chk_id("stall5", 32'h0022_1820, 32'h8, 32'd5);
    rst = 1'b1;
    step();
    chk_rst("rst1");
    rst = 1'b0;

    br_taken  = 1'b1;
    br_target = 32'h80;
    step();
    chk("oor.bub", {31'h0, id_valid}, 32'h0);
    chk("oor.addr0", rom_addr, 32'h80);
    br_taken = 1'b0;
    id_ready = 1'b1;
    step();
`ifdef FETCH_RANGE_CHECK_EN
    chk("oor.valid", {31'h0, id_valid}, 32'h0);
    chk("oor.err", {31'h0, fetch_err}, 32'h1);
    chk("oor.addr", rom_addr, 32'h80);
    step();
    chk("oor.hold", rom_addr, 32'h80);
    chk("oor.cnt", fetch_cnt, 32'h0);
    br_taken  = 1'b1;
    br_target = 32'h4;
    step();
    chk("oor.redir", rom_addr, 32'h4);
    br_taken = 1'b0;
    step();
    chk_id("oor.back", 32'h3c02_0101, 32'h4, 32'd1);
    chk("oor.sticky", {31'h0, fetch_err}, 32'h1);
`else
    chk_id("alias", 32'h3c01_1010, 32'h80, 32'd1);
    chk("alias.err", {31'h0, fetch_err}, 32'h0);
    chk("alias.addr", rom_addr, 32'h84);

    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    step();
    chk("wrap.addr0", rom_addr, 32'hFFFF_FFFC);
    br_taken = 1'b0;
    step();
    chk("wrap.pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4", id_pc4, 32'h0);
    chk("wrap.inst", id_inst, 32'hA5A5_001F);
    chk("wrap.addr", rom_addr, 32'h0);
    chk("wrap.cnt", fetch_cnt, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
